systolic_os_engine: RTL and testbench
=====================================

# systolic_os_engine

Parametrised output-stationary systolic matrix-multiply engine; successor to the fixed 2x2 `systolic` array. Computes C = A x B for an ROWS x K by K x COLS problem, with run-time K and unsigned or signed operands. Skewing is done internally, so the feeder supplies one unskewed A column and B row per beat under a valid/ready handshake. Results drain one C row at a time through a second handshake to the downstream writeback logic.

## Interface
- ROWS, 2, PE rows (≥1)
- COLS, 2, PE columns (≥1)
- DATA_WIDTH, 4, operand width
- ACC_WIDTH, 12, accumulator/result width (≥2*DATA_WIDTH)
- K_MAX, 255, largest supported inner dimension; KW = $clog2(K_MAX+1)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  job request; honoured only in IDLE
- signed_mode  in  1  sampled with start: 1 = two's-complement operands
- k_len  in  KW  inner dimension, sampled with start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  feeder beat valid
- in_ready  out  1  high only in LOAD
- a_col  in  ROWS*DATA_WIDTH  A[i][k] in slice i (row 0 = LSBs)
- b_row  in  COLS*DATA_WIDTH  B[k][j] in slice j (col 0 = LSBs)
- out_valid  out  1  C row available
- out_ready  in  1  downstream accepts row
- out_row  out  COLS*ACC_WIDTH  C[r][j] in slice j
- out_row_idx  out  $clog2(ROWS) (min 1)  index r of current row
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: start=1 latches k_len and signed_mode, clears all accumulators and skew/PE pipeline registers. Next state is LOAD, or DRAIN if k_len=0.
- LOAD: in_ready=1. A beat is accepted when in_valid&&in_ready. After k_len accepted beats, next state is FLUSH.
- Bubbles: a cycle with no accepted beat injects zero on every a and b lane. The array advances every cycle, so bubbles never stall the array and never corrupt alignment.
- Skew: lane i of a_col is delayed i cycles; lane j of b_row is delayed j cycles.
- PE(i,j): acc += a_in*b_in. The product is extended to ACC_WIDTH (zero-extended, or sign-extended when signed_mode). The PE registers a to PE(i,j+1) and b to PE(i+1,j).
- Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
- FLUSH: lasts exactly ROWS+COLS-1 cycles, then DRAIN.
- DRAIN: presents rows r=0..ROWS-1 in order.
  - out_valid=1 and out_row/out_row_idx are stable while out_ready=0.
  - Each out_valid&&out_ready advances r.
  - The handshake on r=ROWS-1 moves to IDLE and pulses done.
- start while busy is ignored. in_valid outside LOAD is ignored.
- reset=0 at any edge, including mid-job: every register and all outputs return to reset values and the state goes to IDLE.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_row=0, out_row_idx=0, done=0; all accumulators 0.
- start sampled at edge S: busy=1 and in_ready=1 from after S.
- Beat accepted at edge E: its term lands in PE(i,j)'s accumulator at edge E+i+j+1.
- The last term lands in PE(ROWS-1,COLS-1) at or before the final FLUSH edge.
- out_valid rises the cycle after FLUSH ends.
- Minimum job latency (no bubbles, out_ready=1): 1 + k_len + (ROWS+COLS-1) + ROWS cycles from start to done.
- done is high for exactly the cycle after the final drain handshake.
- A new start is accepted in that same cycle, since the state is IDLE.
- k_len=0: in_ready never rises; ROWS all-zero rows are drained.

## Test plan
- Basic multiply, 2x2, unsigned, k_len=2. A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Beats: a_col={3,1}, b_row={6,5}; then a_col={4,2}, b_row={8,7}. Required: row0={22,19}, row1={50,43}, then done, busy=0.
- Feeder bubbles: same job with in_valid low for 3 cycles between beats. Required: identical result; total latency grows by 3.
- Output backpressure: out_ready held low 5 cycles in DRAIN. Required: out_valid=1, out_row_idx=0 and row0={22,19} held stable; rows then emerge in order; done one cycle after the row-1 handshake.
- Signed mode: signed_mode=1, A=[[-1,2],[3,-4]] (4'hF,4'h2,4'h3,4'hC), B=identity. Required: row0={12'h002,12'hFFF}, row1={12'hFFC,12'h003}.
- k_len=0 and wrap: k_len=0 gives two zero rows with in_ready never high. A separate ACC_WIDTH=8 run with k_len=2 and all operands 15 (450 mod 256) gives every C element 194.
- Reset mid-LOAD: reset=0 for one edge after 1 beat. Required: all outputs at reset values next cycle. A following full basic job returns {22,19},{50,43}.

Source files
------------

// File: rtl/systolic_os_engine.sv
// Output-stationary systolic matrix-multiply engine: C = A x B with internal
// input skew, run-time inner dimension and a row-at-a-time drain handshake.
module systolic_os_engine #(
  parameter int  ROWS       = 2,
  parameter int  COLS       = 2,
  parameter int  DATA_WIDTH = 4,
  parameter int  ACC_WIDTH  = 12,
  parameter int  K_MAX      = 255,
  localparam int KW         = $clog2(K_MAX + 1),
  localparam int RIW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       signed_mode_i,
  input  logic [KW-1:0]              k_len_i,
  output logic                       busy_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0] a_col_i,
  input  logic [COLS*DATA_WIDTH-1:0] b_row_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [COLS*ACC_WIDTH-1:0]  out_row_o,
  output logic [RIW-1:0]             out_row_idx_o,
  output logic                       done_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam int CW = $clog2(K_MAX + ROWS + COLS + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(ROWS + COLS - 2);

  logic [1:0]     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RIW-1:0] row_q, row_d;
  logic           signed_q, signed_d;
  logic           done_q, done_d;
  logic           accept, clear;

  assign accept = (state_q == LOAD) && in_valid_i;
  assign clear  = (state_q == IDLE) && start_i;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    signed_d = signed_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        k_d      = k_len_i;
        signed_d = signed_mode_i;
        cnt_d    = '0;
        row_d    = '0;
        state_d  = (k_len_i == '0) ? DRAIN : LOAD;
      end
      LOAD: if (in_valid_i) begin
        if (CW'(k_q) == cnt_q + CW'(1)) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        // Long enough for the last beat to reach the far corner PE.
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: if (out_ready_i) begin
        if (row_q == RIW'(ROWS - 1)) begin
          row_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + RIW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      signed_q <= signed_d;
      done_q   <= done_d;
    end
  end

  logic [DATA_WIDTH-1:0] a_skew [ROWS];
  logic [DATA_WIDTH-1:0] b_skew [COLS];
  logic [DATA_WIDTH-1:0] a_fw   [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_fw   [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_arr[ROWS][COLS];

  genvar gi, gj;
  generate
    // Lane i is held i+1 registers; idle cycles inject zero so the array never stalls.
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
      logic [DATA_WIDTH-1:0] sr_q [gi+1];
      always_ff @(posedge clk_i) begin
        if (!reset_i || clear) begin
          for (int s = 0; s <= gi; s++) sr_q[s] <= '0;
        end else begin
          sr_q[0] <= accept ? a_col_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) sr_q[s] <= sr_q[s-1];
        end
      end
      assign a_skew[gi] = sr_q[gi];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
      logic [DATA_WIDTH-1:0] sr_q [gi+1];
      always_ff @(posedge clk_i) begin
        if (!reset_i || clear) begin
          for (int s = 0; s <= gi; s++) sr_q[s] <= '0;
        end else begin
          sr_q[0] <= accept ? b_row_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) sr_q[s] <= sr_q[s-1];
        end
      end
      assign b_skew[gi] = sr_q[gi];
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        logic [DATA_WIDTH-1:0]          a_in, b_in, a_q, b_q;
        logic signed [2*DATA_WIDTH-1:0] prod_s;
        logic [2*DATA_WIDTH-1:0]        prod_u;
        logic signed [ACC_WIDTH-1:0]    ext_s;
        logic [ACC_WIDTH-1:0]           prod_ext, acc_q;

        if (gj == 0) begin : g_a_edge
          assign a_in = a_skew[gi];
        end else begin : g_a_link
          assign a_in = a_fw[gi][gj-1];
        end
        if (gi == 0) begin : g_b_edge
          assign b_in = b_skew[gj];
        end else begin : g_b_link
          assign b_in = b_fw[gi-1][gj];
        end

        assign prod_s = $signed({{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in}) *
                        $signed({{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in});
        assign prod_u = {{DATA_WIDTH{1'b0}}, a_in} * {{DATA_WIDTH{1'b0}}, b_in};
        assign ext_s    = ACC_WIDTH'(prod_s);
        assign prod_ext = signed_q ? $unsigned(ext_s) : ACC_WIDTH'(prod_u);

        always_ff @(posedge clk_i) begin
          if (!reset_i || clear) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
          end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_q + prod_ext;
          end
        end

        assign a_fw[gi][gj]    = a_q;
        assign b_fw[gi][gj]    = b_q;
        assign acc_arr[gi][gj] = acc_q;
      end
    end
  endgenerate

  always_comb begin
    out_row_o = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < COLS; j++) out_row_o[j*ACC_WIDTH +: ACC_WIDTH] = acc_arr[row_q][j];
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign in_ready_o    = (state_q == LOAD);
  assign out_valid_o   = (state_q == DRAIN);
  assign out_row_idx_o = row_q;
  assign done_o        = done_q;
endmodule

// File: tb/tb_systolic_os_engine.sv
// Self-checking bench for systolic_os_engine: directed and random jobs checked
// against a plain matrix-product model, on a 12-bit and an 8-bit accumulator build.
module tb_systolic_os_engine;
  localparam int ROWS = 2, COLS = 2, DW = 4, AW = 12, AW8 = 8, KW = 8, RIW = 1, KT = 16;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, sgn_mode = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic [ROWS*DW-1:0] a_col = '0;
  logic [COLS*DW-1:0] b_row = '0;

  logic busy, in_ready, out_valid, done;
  logic [COLS*AW-1:0] out_row;
  logic [RIW-1:0]     out_idx;
  logic busy8, in_ready8, out_valid8, done8;
  logic [COLS*AW8-1:0] out_row8;
  logic [RIW-1:0]      out_idx8;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int unsigned A [ROWS][KT];
  int unsigned B [KT][COLS];

  always #5 clk = ~clk;

  systolic_os_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(255)) dut (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .signed_mode_i(sgn_mode), .k_len_i(k_len),
    .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready), .a_col_i(a_col), .b_row_i(b_row),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_row_o(out_row),
    .out_row_idx_o(out_idx), .done_o(done));

  systolic_os_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW8), .K_MAX(255)) dut8 (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .signed_mode_i(sgn_mode), .k_len_i(k_len),
    .busy_o(busy8), .in_valid_i(in_valid), .in_ready_o(in_ready8), .a_col_i(a_col), .b_row_i(b_row),
    .out_valid_o(out_valid8), .out_ready_i(out_ready), .out_row_o(out_row8),
    .out_row_idx_o(out_idx8), .done_o(done8));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // C[r][j] = sum_k A[r][k]*B[k][j], reduced modulo 2^aw, packed with column 0 in the LSBs.
  function automatic logic [63:0] model_row(int r, int k, bit sgn, int aw);
    logic [63:0] row;
    longint s, av, bv;
    row = '0;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++) begin
        av = (sgn && A[r][kk] >= 8) ? longint'(A[r][kk]) - 16 : longint'(A[r][kk]);
        bv = (sgn && B[kk][j] >= 8) ? longint'(B[kk][j]) - 16 : longint'(B[kk][j]);
        s += av * bv;
      end
      row |= (64'(s) & ((64'd1 << aw) - 64'd1)) << (j * aw);
    end
    return row;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".out_row"}, out_row, 0);
    check({tag, ".out_idx"}, out_idx, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".busy8"}, busy8, 0);
    check({tag, ".out_row8"}, out_row8, 0);
  endtask

  task automatic set_basic();
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
  endtask

  // One full job; gap1 bubbles before beat 1, bp0 stalled cycles on row 0, or random if rnd.
  task automatic run_job(input int k, input bit sgn, input int gap1, input int bp0, input bit rnd,
                         input string tag);
    logic [63:0] e12 [ROWS];
    logic [63:0] e8 [ROWS];
    int g, bp, t, nb, exp_lat;
    bit saw_ready;
    g = 0; bp = 0; saw_ready = 0;
    for (int r = 0; r < ROWS; r++) begin
      e12[r] = model_row(r, k, sgn, AW);
      e8[r]  = model_row(r, k, sgn, AW8);
    end
    k_len = KW'(k); sgn_mode = sgn; start = 1'b1;
    in_valid = 1'($urandom_range(0, 1)); a_col = ROWS*DW'($urandom); b_row = COLS*DW'($urandom);
    cyc = 1;
    step();
    start = 1'b0; sgn_mode = ~sgn; k_len = KW'($urandom);
    check({tag, ".busy"}, busy, 1);
    for (int kk = 0; kk < k; kk++) begin
      nb = rnd ? int'($urandom_range(0, 2)) : ((kk == 1) ? gap1 : 0);
      for (int q = 0; q < nb; q++) begin
        in_valid = 1'b0; a_col = ROWS*DW'($urandom); b_row = COLS*DW'($urandom);
        step();
        g++;
      end
      check({tag, ".in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = DW'(A[i][kk]);
      for (int j = 0; j < COLS; j++) b_row[j*DW +: DW] = DW'(B[kk][j]);
      step();
    end
    t = 0;
    while (out_valid !== 1'b1 && t < 64) begin
      if (in_ready) saw_ready = 1;
      in_valid = 1'b1; a_col = ROWS*DW'($urandom); b_row = COLS*DW'($urandom);
      step();
      t++;
    end
    check({tag, ".ready_outside_load"}, saw_ready, 0);
    check({tag, ".out_valid_rise"}, out_valid, 1);
    for (int r = 0; r < ROWS; r++) begin
      nb = rnd ? int'($urandom_range(0, 3)) : ((r == 0) ? bp0 : 0);
      for (int q = 0; q <= nb; q++) begin
        check($sformatf("%s.r%0d.valid", tag, r), out_valid, 1);
        check($sformatf("%s.r%0d.idx", tag, r), out_idx, r);
        check($sformatf("%s.r%0d.row", tag, r), out_row, e12[r]);
        check($sformatf("%s.r%0d.row8", tag, r), out_row8, e8[r]);
        check($sformatf("%s.r%0d.valid8", tag, r), out_valid8, 1);
        out_ready = (q == nb);
        in_valid = 1'($urandom_range(0, 1)); a_col = ROWS*DW'($urandom);
        if (q != nb) bp++;
        step();
      end
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".done8"}, done8, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".valid_end"}, out_valid, 0);
    exp_lat = (k == 0) ? 1 + ROWS + bp : 1 + k + g + (ROWS + COLS - 1) + ROWS + bp;
    check({tag, ".latency"}, cyc - 1, exp_lat);
    out_ready = 1'($urandom_range(0, 1)); in_valid = 1'b0;
    step();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check_idle("reset");

    set_basic();
    run_job(2, 0, 0, 0, 0, "basic");
    run_job(2, 0, 3, 0, 0, "bubbles");
    run_job(2, 0, 0, 5, 0, "backpressure");

    A[0][0] = 4'hF; A[0][1] = 4'h2; A[1][0] = 4'h3; A[1][1] = 4'hC;
    B[0][0] = 1; B[0][1] = 0; B[1][0] = 0; B[1][1] = 1;
    run_job(2, 1, 0, 0, 0, "signed");

    run_job(0, 0, 0, 0, 0, "k0");

    for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < 2; kk++) A[i][kk] = 15;
    for (int kk = 0; kk < 2; kk++) for (int j = 0; j < COLS; j++) B[kk][j] = 15;
    run_job(2, 0, 0, 0, 0, "wrap");

    set_basic();
    k_len = 8'd2; sgn_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b1; a_col = {4'd3, 4'd1}; b_row = {4'd6, 4'd5};
    step();
    in_valid = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_idle("reset_mid_load");
    run_job(2, 0, 0, 0, 0, "after_reset");

    for (int n = 0; n < 6; n++) begin
      int k;
      k = int'($urandom_range(1, KT));
      for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < KT; kk++) A[i][kk] = $urandom_range(0, 15);
      for (int kk = 0; kk < KT; kk++) for (int j = 0; j < COLS; j++) B[kk][j] = $urandom_range(0, 15);
      run_job(k, 1'($urandom_range(0, 1)), 0, 0, 1, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
